period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_if.sv | 40 ++++
 rtl/period_meter.sv | 147 ++++++++++++++
 tb/tb_period_meter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/period_meter_if.sv
// Signal bundle for period_meter: measured input, enable and measurement results.
//   sig_in    : measured signal, asynchronous to clk
//   en        : measurement enable, synchronous to clk
//   period    : last measured period in clk cycles
//   high_time : clk cycles the signal was high within that period
//   valid     : one-cycle pulse when period/high_time update
//   overflow  : period counter saturated since the last valid measurement
//   locked    : last two measured periods were equal
// master = stimulus/consumer side, slave = the meter itself.
interface period_meter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             sig_in;
    logic             en;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             overflow;
    logic             locked;

    modport master (
        output sig_in,
        output en,
        input  period,
        input  high_time,
        input  valid,
        input  overflow,
        input  locked
    );

    modport slave (
        input  sig_in,
        input  en,
        output period,
        output high_time,
        output valid,
        output overflow,
        output locked
    );
endinterface

// File: rtl/period_meter.sv
// Measures the period and high time of an asynchronous signal in clk cycles.
// Ports:
//   clk : single clock, all state updates on its rising edge
//   res : asynchronous active-low reset
//   bus : period_meter_if.slave (sig_in/en in; period, high_time, valid,
//         overflow, locked out -- all outputs registered)
// Results are produced at every synchronized rising edge of sig_in except
// the first one after idle, overflow or reset, which only starts a count.
module period_meter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic           clk,
    input  logic           res,
    period_meter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEAS = 2'd1;
    localparam logic [1:0] ST_OVF  = 2'd2;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    // Synchronizer (s1, s2) plus history flop for edge detection
    logic s1_q, s2_q, s3_q;
    logic rise_c;

    logic [1:0]       state_q,       state_d;
    logic [WIDTH-1:0] per_cnt_q,     per_cnt_d;
    logic [WIDTH-1:0] hi_cnt_q,      hi_cnt_d;
    logic [WIDTH-1:0] prev_period_q, prev_period_d;
    logic             prev_vld_q,    prev_vld_d;
    logic [WIDTH-1:0] period_q,      period_d;
    logic [WIDTH-1:0] high_time_q,   high_time_d;
    logic             valid_q,       valid_d;
    logic             overflow_q,    overflow_d;
    logic             locked_q,      locked_d;

    assign rise_c = s2_q & ~s3_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            state_q       <= ST_IDLE;
            per_cnt_q     <= '0;
            hi_cnt_q      <= '0;
            prev_period_q <= '0;
            prev_vld_q    <= 1'b0;
            period_q      <= '0;
            high_time_q   <= '0;
            valid_q       <= 1'b0;
            overflow_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            s1_q          <= bus.sig_in;
            s2_q          <= s1_q;
            s3_q          <= s2_q;
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            hi_cnt_q      <= hi_cnt_d;
            prev_period_q <= prev_period_d;
            prev_vld_q    <= prev_vld_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            valid_q       <= valid_d;
            overflow_q    <= overflow_d;
            locked_q      <= locked_d;
        end
    end

    // Next-state and result logic; a low enable overrides everything else
    always_comb begin
        state_d       = state_q;
        per_cnt_d     = per_cnt_q;
        hi_cnt_d      = hi_cnt_q;
        prev_period_d = prev_period_q;
        prev_vld_d    = prev_vld_q;
        period_d      = period_q;
        high_time_d   = high_time_q;
        valid_d       = 1'b0;
        overflow_d    = overflow_q;
        locked_d      = locked_q;

        if (!bus.en) begin
            state_d    = ST_IDLE;
            per_cnt_d  = '0;
            hi_cnt_d   = '0;
            prev_vld_d = 1'b0;
            locked_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_c) begin
                        state_d   = ST_MEAS;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                    end
                end
                ST_MEAS: begin
                    if (rise_c) begin
                        period_d      = per_cnt_q;
                        high_time_d   = hi_cnt_q;
                        valid_d       = 1'b1;
                        overflow_d    = 1'b0;
                        locked_d      = prev_vld_q && (per_cnt_q == prev_period_q);
                        prev_period_d = per_cnt_q;
                        prev_vld_d    = 1'b1;
                        per_cnt_d     = CNT_ONE;
                        hi_cnt_d      = CNT_ONE;
                    end else if (per_cnt_q == CNT_MAX) begin
                        // Saturate: hold counters, next rise only restarts
                        state_d    = ST_OVF;
                        overflow_d = 1'b1;
                        locked_d   = 1'b0;
                        prev_vld_d = 1'b0;
                    end else begin
                        // hi_cnt only advances alongside per_cnt, so it never exceeds it
                        per_cnt_d = per_cnt_q + CNT_ONE;
                        if (s2_q) begin
                            hi_cnt_d = hi_cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_OVF: begin
                    if (rise_c) begin
                        state_d   = ST_MEAS;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_time_q;
    assign bus.valid     = valid_q;
    assign bus.overflow  = overflow_q;
    assign bus.locked    = locked_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter (WIDTH=4 so saturation is reachable quickly).
// Stimulus pushes hand-computed results; a forked monitor pops on every valid.
module tb_period_meter;

    localparam int unsigned TW = 4;

    typedef struct {
        int per;
        int hi;
        int lck;
    } exp_t;

    logic clk = 1'b0;
    logic res;

    period_meter_if #(.WIDTH(TW)) bus ();

    period_meter #(.WIDTH(TW)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   lat_armed = 1'b0;
    bit   lat_seen  = 1'b0;
    int   lat_start = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_v(input int p, input int h, input int l);
        exp_t e;
        e.per = p;
        e.hi  = h;
        e.lck = l;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic lvl, input int n);
        bus.sig_in = lvl;
        repeat (n) tick();
    endtask

    task automatic rep(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            seg(1'b1, hi);
            seg(1'b0, lo);
        end
    endtask

    // Pops one expectation per valid pulse; a valid with nothing queued is an error
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (res && bus.valid) begin
                if (lat_armed && !lat_seen) begin
                    check("valid_latency", cyc - lat_start, 3);
                    lat_seen = 1'b1;
                end
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("period", int'(bus.period), e.per);
                    check("high_time", int'(bus.high_time), e.hi);
                    check("locked", int'(bus.locked), e.lck);
                    check("overflow_at_valid", int'(bus.overflow), 0);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res        = 1'b0;
        bus.en     = 1'b0;
        bus.sig_in = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) tick();
        check("rst_period", int'(bus.period), 0);
        check("rst_high_time", int'(bus.high_time), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_locked", int'(bus.locked), 0);

        res    = 1'b1;
        bus.en = 1'b1;
        seg(1'b0, 3);

        // 3 high / 4 low x5 then 4 high / 5 low x2
        expect_v(7, 3, 0);
        repeat (4) expect_v(7, 3, 1);
        expect_v(9, 4, 0);
        expect_v(9, 4, 1);
        rep(3, 4, 5);
        rep(4, 5, 2);

        // Third 9-cycle period with enable dropped for two low cycles
        seg(1'b1, 4);
        seg(1'b0, 2);
        bus.en = 1'b0;
        seg(1'b0, 2);
        bus.en = 1'b1;
        seg(1'b0, 1);
        check("en_drop_locked", int'(bus.locked), 0);
        check("en_drop_period_hold", int'(bus.period), 9);
        check("en_drop_high_hold", int'(bus.high_time), 4);

        // Restart after enable: first rise only arms, second gives locked=0
        expect_v(9, 4, 0);
        expect_v(9, 4, 1);
        rep(4, 5, 3);

        // 1-cycle pulse every 5 cycles
        expect_v(9, 4, 1);
        expect_v(5, 1, 0);
        expect_v(5, 1, 1);
        expect_v(5, 1, 1);
        rep(1, 4, 4);

        // One rise then held high long enough to saturate the 4-bit counter
        expect_v(5, 1, 1);
        seg(1'b1, 30);
        check("ovf_flag", int'(bus.overflow), 1);
        check("ovf_locked", int'(bus.locked), 0);
        check("ovf_period_hold", int'(bus.period), 5);
        check("ovf_high_hold", int'(bus.high_time), 1);
        seg(1'b0, 3);

        // Rise out of overflow restarts without a result; overflow clears at next valid
        rep(2, 4, 1);
        check("ovf_held_after_restart", int'(bus.overflow), 1);
        expect_v(6, 2, 0);
        expect_v(6, 2, 1);
        rep(2, 4, 1);
        seg(1'b1, 2);
        seg(1'b0, 3);

        // Asynchronous reset mid-measurement, between clock edges
        @(negedge clk);
        #2;
        res = 1'b0;
        #1;
        check("mid_rst_period", int'(bus.period), 0);
        check("mid_rst_high_time", int'(bus.high_time), 0);
        check("mid_rst_valid", int'(bus.valid), 0);
        check("mid_rst_overflow", int'(bus.overflow), 0);
        check("mid_rst_locked", int'(bus.locked), 0);
        #1;
        res = 1'b1;
        seg(1'b0, 3);

        // Clean restart after reset; latency measured on the first valid
        expect_v(6, 2, 0);
        expect_v(6, 2, 1);
        rep(2, 4, 1);
        lat_start = cyc;
        lat_armed = 1'b1;
        rep(2, 4, 1);
        rep(2, 4, 1);
        seg(1'b0, 6);

        check("pending_expectations", sb_q.size(), 0);
        check("latency_observed", int'(lat_seen), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
